// File: rtl/host_csr_file.sv
// host_csr_file
// Host-facing control/status register file for a TSIM accelerator. It decodes
// host MMIO reads and writes, keeps NUM_ARGS argument registers, exposes
// NUM_STATUS read-only status words, and runs a busy/done sequencer with a
// cycle counter, a sticky done flag (write-1-to-clear) and an interrupt.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   host_req_*            host request channel (valid, opcode 1=wr, addr, value)
//   host_req_deq          request consumed this cycle
//   host_resp_valid/bits  read response, one-cycle pulse the cycle after deq
//   launch                high while the accelerator job is running
//   finish                single-cycle job-complete pulse from the accelerator
//   irq                   done & irq_en
//   args                  argument registers, arg k at [k*W +: W]
//   status_in             status words, sampled at the read deq edge
//
// Address map (byte addresses, word aligned)
//   0x00 CTRL {irq_en, done, busy}   0x04 CYCLES   0x08 ID
//   0x0C + 4k ARG k                  0x0C + 4*NUM_ARGS + 4j STATUS j

module host_csr_arg_reg #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] q
);
    always_ff @(posedge clock) begin
        if (reset)      q <= '0;
        else if (wr_en) q <= wr_data;
    end
endmodule

module host_csr_file #(
    parameter int HOST_ADDR_BITS = 8,
    parameter int HOST_DATA_BITS = 32,
    parameter int NUM_ARGS       = 4,
    parameter int NUM_STATUS     = 2
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  host_req_valid,
    input  logic                                  host_req_opcode,
    input  logic [HOST_ADDR_BITS-1:0]             host_req_addr,
    input  logic [HOST_DATA_BITS-1:0]             host_req_value,
    output logic                                  host_req_deq,
    output logic                                  host_resp_valid,
    output logic [HOST_DATA_BITS-1:0]             host_resp_bits,
    output logic                                  launch,
    input  logic                                  finish,
    output logic                                  irq,
    output logic [NUM_ARGS*HOST_DATA_BITS-1:0]    args,
    input  logic [((NUM_STATUS > 0) ? NUM_STATUS : 1)*HOST_DATA_BITS-1:0] status_in
);
    localparam int W         = HOST_DATA_BITS;
    localparam int IW        = HOST_ADDR_BITS - 2;
    localparam int ARG_BASE  = 3;
    localparam int STAT_BASE = ARG_BASE + NUM_ARGS;
    localparam logic [15:0] ID_VAL = {8'(NUM_STATUS), 8'(NUM_ARGS)};

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    logic [0:0]                 state;
    logic                       busy, done, irq_en;
    logic [W-1:0]               cycles;
    logic [NUM_ARGS-1:0][W-1:0] arg_q;

    logic [IW-1:0] widx;
    logic          aligned, wr, rd, ctrl_wr, launch_go, fin_go;
    logic [W-1:0]  rdata;

    assign widx    = host_req_addr[HOST_ADDR_BITS-1:2];
    assign aligned = (host_req_addr[1:0] == 2'b00);

    // Nothing is consumed during reset, so a read issued alongside reset
    // never produces a response.
    assign host_req_deq = !reset && (state == ST_IDLE) && host_req_valid;
    assign wr           = host_req_deq && host_req_opcode;
    assign rd           = host_req_deq && !host_req_opcode;

    assign ctrl_wr   = wr && aligned && (widx == IW'(0));
    assign launch_go = ctrl_wr && host_req_value[0] && !busy;
    assign fin_go    = finish && busy;

    assign launch = busy;
    assign irq    = done && irq_en;
    assign args   = arg_q;

    // Read decode; unmapped or misaligned addresses return 0.
    always_comb begin
        rdata = '0;
        if (aligned) begin
            if (widx == IW'(0))      rdata[2:0] = {irq_en, done, busy};
            else if (widx == IW'(1)) rdata = cycles;
            else if (widx == IW'(2)) rdata = W'(ID_VAL);
            for (int k = 0; k < NUM_ARGS; k++)
                if (widx == IW'(ARG_BASE + k)) rdata = arg_q[k];
            for (int j = 0; j < NUM_STATUS; j++)
                if (widx == IW'(STAT_BASE + j)) rdata = status_in[j*W +: W];
        end
    end

    // Argument registers are frozen while a job runs.
    for (genvar k = 0; k < NUM_ARGS; k++) begin : g_arg
        host_csr_arg_reg #(.W(W)) u_arg (
            .clock   (clock),
            .reset   (reset),
            .wr_en   (wr && aligned && !busy && (widx == IW'(ARG_BASE + k))),
            .wr_data (host_req_value),
            .q       (arg_q[k])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= ST_IDLE;
            host_resp_valid <= 1'b0;
            host_resp_bits  <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            irq_en          <= 1'b0;
            cycles          <= '0;
        end else begin
            // rd can only be true in IDLE, so READ always falls back to IDLE.
            state           <= rd ? ST_READ : ST_IDLE;
            host_resp_valid <= rd;
            if (rd) host_resp_bits <= rdata;

            if (ctrl_wr) irq_en <= host_req_value[2];

            // launch_go needs !busy and fin_go needs busy, so they never
            // coincide; finish beats a same-cycle W1C of done.
            if (fin_go) begin
                busy <= 1'b0;
                done <= 1'b1;
            end else begin
                if (launch_go) busy <= 1'b1;
                if (launch_go || (ctrl_wr && host_req_value[1])) done <= 1'b0;
            end

            // Counts every busy cycle including the finish cycle; saturates.
            if (launch_go)
                cycles <= '0;
            else if (busy && (cycles != '1))
                cycles <= cycles + W'(1);
        end
    end
endmodule

// File: tb/tb_host_csr_file.sv
module tb_host_csr_file;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0, req_op = 1'b0;
    logic [7:0]   req_addr = '0;
    logic [31:0]  req_value = '0;
    logic         finish = 1'b0;
    logic [63:0]  status_in = '0;
    logic         host_req_deq, host_resp_valid, launch, irq;
    logic [31:0]  host_resp_bits;
    logic [127:0] args;

    // Narrow instance: 4-bit data, one arg, no status words.
    logic         b_valid = 1'b0, b_op = 1'b0, b_finish = 1'b0;
    logic [7:0]   b_addr = '0;
    logic [3:0]   b_value = '0, b_status = '0;
    logic         b_deq, b_resp_valid, b_launch, b_irq;
    logic [3:0]   b_resp_bits, b_args;

    int checks = 0, failures = 0;
    bit checking = 1'b0;

    always #5 clock = ~clock;

    host_csr_file dut (
        .clock(clock), .reset(reset),
        .host_req_valid(req_valid), .host_req_opcode(req_op),
        .host_req_addr(req_addr), .host_req_value(req_value),
        .host_req_deq(host_req_deq), .host_resp_valid(host_resp_valid),
        .host_resp_bits(host_resp_bits), .launch(launch), .finish(finish),
        .irq(irq), .args(args), .status_in(status_in)
    );

    host_csr_file #(.HOST_ADDR_BITS(8), .HOST_DATA_BITS(4), .NUM_ARGS(1), .NUM_STATUS(0)) dut_b (
        .clock(clock), .reset(reset),
        .host_req_valid(b_valid), .host_req_opcode(b_op),
        .host_req_addr(b_addr), .host_req_value(b_value),
        .host_req_deq(b_deq), .host_resp_valid(b_resp_valid),
        .host_resp_bits(b_resp_bits), .launch(b_launch), .finish(b_finish),
        .irq(b_irq), .args(b_args), .status_in(b_status)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_busy = 0, m_done = 0, m_irq_en = 0, m_pend = 0;
    logic [31:0] m_cycles = '0;
    logic [31:0] m_args [4] = '{default: '0};
    logic [31:0] sb [$];
    bit          m_deq, m_ctrl, m_launch, m_fin, m_b0;

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int w;
        if (a[1:0] != 2'b00) return 32'h0;
        w = int'(a) / 4;
        if (w == 0) return {29'd0, m_irq_en, m_done, m_busy};
        if (w == 1) return m_cycles;
        if (w == 2) return 32'h0000_0204;
        if (w >= 3 && w < 7) return m_args[w-3];
        if (w >= 7 && w < 9) return status_in[(w-7)*32 +: 32];
        return 32'h0;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_irq_en = 0; m_pend = 0; m_cycles = '0;
            for (int i = 0; i < 4; i++) m_args[i] = '0;
        end else begin
            m_deq = req_valid && !m_pend;
            m_b0  = m_busy;
            if (m_pend) m_pend = 0;
            else if (m_deq && !req_op) begin
                sb.push_back(model_read(req_addr));
                m_pend = 1;
            end
            m_ctrl   = m_deq && req_op && (req_addr == 8'h00);
            m_launch = m_ctrl && req_value[0] && !m_b0;
            m_fin    = finish && m_b0;
            if (m_deq && req_op && !m_b0 && req_addr[1:0] == 2'b00 && req_addr >= 8'd12 && req_addr < 8'd28)
                m_args[(int'(req_addr) - 12) / 4] = req_value;
            if (m_launch) m_cycles = '0;
            else if (m_b0 && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
            if (m_ctrl) m_irq_en = req_value[2];
            if (m_fin) begin
                m_busy = 0; m_done = 1;
            end else begin
                if (m_launch) begin m_busy = 1; m_done = 0; end
                if (m_ctrl && req_value[1]) m_done = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (checking) begin
            chk("deq", host_req_deq, !reset && req_valid && !m_pend);
            chk("resp_valid", host_resp_valid, m_pend);
            chk("launch", launch, m_busy);
            chk("irq", irq, m_done && m_irq_en);
            chk("args", args, {m_args[3], m_args[2], m_args[1], m_args[0]});
            if (host_resp_valid) begin
                if (sb.size() == 0) chk("resp_unexpected", 1'b1, 1'b0);
                else chk("rdata", host_resp_bits, sb.pop_front());
            end
        end
    end

    // ---------------- stimulus (called at posedge+1) ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] v);
        req_valid = 1; req_op = 1; req_addr = a; req_value = v;
        step(1);
        req_valid = 0;
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp, input string name);
        req_valid = 1; req_op = 0; req_addr = a;
        step(1);
        req_valid = 0;
        chk(name, host_resp_bits, exp);
        step(1);
    endtask

    task automatic b_rd_chk(input logic [7:0] a, input logic [3:0] exp, input string name);
        b_valid = 1; b_op = 0; b_addr = a;
        step(1);
        b_valid = 0;
        chk({name, "_valid"}, b_resp_valid, 1'b1);
        chk(name, b_resp_bits, exp);
        step(1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] addr_tab [13] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18,
                                  8'h1C, 8'h20, 8'h24, 8'h0D, 8'h02, 8'hFF};

    initial begin
        int cnt;
        step(3);
        reset = 0;
        checking = 1;
        chk("rst_launch", launch, 1'b0);
        chk("rst_irq", irq, 1'b0);
        rd_chk(8'h00, 32'h0, "rst_ctrl");
        rd_chk(8'h04, 32'h0, "rst_cycles");
        rd_chk(8'h0C, 32'h0, "rst_arg0");
        rd_chk(8'h08, 32'h204, "id");

        wr(8'h0C, 32'hDEADBEEF);
        wr(8'h18, 32'h12345678);
        chk("arg0_out", args[31:0], 32'hDEADBEEF);
        chk("arg3_out", args[127:96], 32'h12345678);
        rd_chk(8'h0C, 32'hDEADBEEF, "arg0_rd");
        rd_chk(8'h18, 32'h12345678, "arg3_rd");
        rd_chk(8'h0D, 32'h0, "misaligned");

        // job of 10 busy cycles
        wr(8'h00, 32'h5);
        for (int i = 0; i < 9; i++) begin
            chk("launch_hi", launch, 1'b1);
            step(1);
        end
        chk("launch_hi", launch, 1'b1);
        finish = 1; step(1); finish = 0;
        chk("launch_lo", launch, 1'b0);
        chk("irq_set", irq, 1'b1);
        rd_chk(8'h04, 32'd10, "cycles10");
        rd_chk(8'h00, 32'h6, "ctrl_done");
        wr(8'h00, 32'h6);
        chk("irq_clr", irq, 1'b0);
        rd_chk(8'h00, 32'h4, "ctrl_w1c");

        // behaviour while busy
        wr(8'h00, 32'h5);
        step(3);
        wr(8'h10, 32'h7);
        chk("arg1_locked", args[63:32], 32'h0);
        wr(8'h00, 32'h1);
        rd_chk(8'h04, 32'd5, "cycles_no_clear");
        finish = 1; wr(8'h00, 32'h6); finish = 0;
        chk("fin_beats_w1c_irq", irq, 1'b1);
        rd_chk(8'h00, 32'h6, "fin_beats_w1c");
        wr(8'h00, 32'h6);

        // status and read throughput
        status_in = {32'hCAFEF00D, 32'h11111111};
        rd_chk(8'h20, 32'hCAFEF00D, "status1");
        req_valid = 1; req_op = 0; req_addr = 8'h1C;
        cnt = 0;
        repeat (8) begin @(negedge clock); if (host_req_deq) cnt++; end
        @(posedge clock); #1;
        req_valid = 0;
        chk("b2b_rate", cnt, 4);

        // reset during read and mid-job
        wr(8'h00, 32'h5);
        step(2);
        req_valid = 1; req_op = 0; req_addr = 8'h00; reset = 1;
        step(1);
        req_valid = 0;
        chk("rst_no_resp", host_resp_valid, 1'b0);
        chk("rst_launch2", launch, 1'b0);
        reset = 0;
        step(1);
        rd_chk(8'h00, 32'h0, "ctrl_after_rst");
        finish = 1; step(1); finish = 0;
        rd_chk(8'h00, 32'h0, "finish_idle");

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            req_valid = ($urandom_range(99) < 60);
            req_op    = 1'($urandom_range(1));
            req_addr  = addr_tab[$urandom_range(12)];
            req_value = (req_addr == 8'h00) ? 32'($urandom_range(7)) : $urandom;
            finish    = ($urandom_range(15) == 0);
            if ($urandom_range(31) == 0) status_in = {$urandom, $urandom};
            reset     = ($urandom_range(199) == 0);
            step(1);
        end
        req_valid = 0; finish = 0; reset = 0;
        step(3);

        // narrow instance: saturation and no status words
        b_valid = 1; b_op = 1; b_addr = 8'h00; b_value = 4'h1;
        step(1);
        b_valid = 0;
        step(20);
        b_rd_chk(8'h04, 4'hF, "b_cycles_sat");
        chk("b_launch", b_launch, 1'b1);
        b_finish = 1; step(1); b_finish = 0;
        chk("b_launch_lo", b_launch, 1'b0);
        b_valid = 1; b_op = 1; b_addr = 8'h0C; b_value = 4'h9;
        step(1);
        b_valid = 0;
        chk("b_arg0", b_args, 4'h9);
        b_rd_chk(8'h0C, 4'h9, "b_arg0_rd");
        b_rd_chk(8'h10, 4'h0, "b_no_status");

        step(2);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/host_csr_file.md
Name: host_csr_file

Overview:
- Parametrised host control/status register file for TSIM accelerators.
- Supports N argument registers and M read-only status words.
- Adds a built-in busy/done sequencer, an internal cycle counter, a sticky done bit with write-1-to-clear, and an interrupt output.
- Sits between the host MMIO request/response channel and the accelerator core. Replaces per-design fixed register files.

Parameters:
- HOST_ADDR_BITS, 8: host address width; must satisfy (3+NUM_ARGS+NUM_STATUS)*4 <= 2^HOST_ADDR_BITS.
- HOST_DATA_BITS, 32: register and data width; must be >= 3.
- NUM_ARGS, 4: number of host-writable argument registers, range 1..32.
- NUM_STATUS, 2: number of accelerator-driven read-only status words, range 0..16.

Ports:
- clock  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- host_req_valid  in  1  host request present.
- host_req_opcode  in  1  1 = write, 0 = read.
- host_req_addr  in  HOST_ADDR_BITS  byte address.
- host_req_value  in  HOST_DATA_BITS  write data.
- host_req_deq  out  1  request consumed this cycle.
- host_resp_valid  out  1  read data valid, one-cycle pulse.
- host_resp_bits  out  HOST_DATA_BITS  read data.
- launch  out  1  level; high while the accelerator is busy.
- finish  in  1  single-cycle pulse from the accelerator: job complete.
- irq  out  1  interrupt; equals done & irq_en.
- args  out  NUM_ARGS*HOST_DATA_BITS  argument registers; arg k occupies bits [k*W +: W].
- status_in  in  max(NUM_STATUS,1)*HOST_DATA_BITS  status words, sampled on read.

Behaviour:
- Address map (word aligned):
  - 0x00 CTRL: bit0 busy/launch, bit1 done, bit2 irq_en; other bits read 0.
  - 0x04 CYCLES.
  - 0x08 ID: constant {NUM_STATUS[7:0], NUM_ARGS[7:0]}, zero-extended.
  - 0x0C + 4k: ARG k.
  - 0x0C + 4*NUM_ARGS + 4j: STATUS j.
  - Addresses with addr[1:0] != 0 or beyond the map are unmapped.
- Host FSM has two states, IDLE and READ.
  - IDLE: host_req_deq = host_req_valid. A read moves the FSM to READ. A write stays in IDLE and takes effect at the same edge.
  - READ: host_req_deq = 0. host_resp_valid = 1 for exactly one cycle, then the FSM returns to IDLE.
  - Read latency: response appears in the cycle after deq. The maximum read rate is one read every 2 cycles; writes can complete every cycle.
- Read data: captured at the deq edge and held in host_resp_bits until the next read. Unmapped reads return 0. STATUS j returns status_in as sampled at the deq edge.
- CTRL write:
  - bit0 = 1 while not busy: sets busy, clears done, clears CYCLES to 0.
  - bit0 = 1 while busy: ignored.
  - bit0 = 0: never clears busy.
  - bit1 = 1: clears done (W1C).
  - bit2: written directly into irq_en.
- finish while busy: clears busy and sets done at the same edge. finish while not busy: ignored.
- Simultaneous finish and CTRL W1C of done: finish wins, so done = 1.
- Simultaneous launch write and finish while not busy: launch takes effect and finish is ignored.
- CYCLES:
  - Increments by 1 each cycle busy = 1, including the finish cycle.
  - Saturates at all-ones; no wrap.
  - Holds its value when idle. Host writes are ignored.
- ARG k: host-writable only while not busy; writes while busy are dropped but still dequeued. Driven continuously on args.
- Writes to CYCLES, ID, STATUS, or unmapped addresses are dequeued with no effect. Writes never produce a response.
- Reset values: all registers, launch, irq, host_resp_valid, and host_resp_bits are 0; FSM is IDLE. Reset mid-read drops the pending response. Reset mid-job drops busy without setting done.
- When NUM_STATUS = 0, status_in is unused and no STATUS addresses exist.

Test Plan:
- Reset, then read 0x00, 0x04, 0x0C: deq at t, host_resp_valid at t+1, each response 0. Read 0x08 with defaults returns 0x00000204.
- Write ARG0 = 0xDEADBEEF, ARG3 = 0x12345678, then read both: args bits [31:0] = 0xDEADBEEF, bits [127:96] = 0x12345678; reads match. Read 0x0D (misaligned) returns 0.
- Write 0x00 = 0x5 (launch, irq_en), pulse finish 10 cycles later:
  - launch high for 10 cycles.
  - CYCLES reads 10.
  - CTRL reads 0x6.
  - irq = 1.
  - Write 0x00 = 0x6 (W1C done, keep irq_en): irq goes to 0 and CTRL reads 0x4.
- While busy:
  - Write ARG1 = 7: ARG1 unchanged.
  - Re-launch: no effect, and CYCLES is not cleared.
  - Finish pulse arriving in the same cycle as a W1C of done: done = 1.
- Status read: status_in word1 = 0xCAFEF00D; read 0x0C + 4*4 + 4 = 0x20 returns 0xCAFEF00D. Back-to-back reads with valid held high dequeue every 2nd cycle.
- Assert reset during a READ state and mid-job: no host_resp_valid pulse, launch = 0, done = 0. Then drive finish with no job running: done stays 0.
